ex_alu_div: RTL and testbench

- Execute stage. Consumes the registered instruction and operands held in the ID/EX pipeline register and produces the write-back triple (rd_data, rd_addr, regs_wen) for the EX/MEM register.
- RV32I ALU ops and MUL/MULH/MULHSU/MULHU are single-cycle combinational.
- DIV/DIVU/REM/REMU run on a 32-iteration restoring divider. While the divider is busy, stall_o holds ID/EX (its lden is driven low) and everything upstream.

---
 rtl/ex_alu_div.sv | 202 ++++++++++++++++++++
 tb/tb_ex_alu_div.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_div.sv
// Execute stage: RV32I ALU, single-cycle RV32M multiply, and a 32-step
// restoring divider. Produces the write-back triple for EX/MEM.
//
// Hold handshake: stall_o=1 means "this instruction is not finished; keep
// ID/EX and everything upstream frozen". The instruction in ID/EX advances
// only on an edge where stall_o=0, and regs_wen_o is only ever asserted in
// such a cycle.
module ex_alu_div #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] instaddr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic [31:0] instaddr_o,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        regs_wen_o,
  output logic        stall_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t  r_state;
  div_state_t  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_is_rem;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_is_opimm;
  logic        w_is_op;
  logic        w_is_m;
  logic        w_is_div;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_res;
  logic        w_mul_a_sgn;
  logic        w_mul_b_sgn;
  logic signed [65:0] w_mul_a;
  logic signed [65:0] w_mul_b;
  logic signed [65:0] w_mul_prod;
  logic [31:0] w_mul_res;
  logic        w_div_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_div_res;
  logic        w_stall;
  logic        w_unused;

  assign w_opcode   = inst_i[6:0];
  assign w_funct3   = inst_i[14:12];
  assign w_funct7   = inst_i[31:25];
  assign w_is_opimm = (w_opcode == 7'b0010011);
  assign w_is_op    = (w_opcode == 7'b0110011) &&
                      ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
  assign w_is_m     = (w_opcode == 7'b0110011) && (w_funct7 == 7'b0000001);
  assign w_is_div   = w_is_m && w_funct3[2];
  assign w_shamt    = op2_i[4:0];
  assign w_unused   = ^{inst_i[24:15], inst_i[11:7], w_mul_prod[65:64]};

  // Integer ALU shared by OP and OP-IMM; SUB only exists in the OP encoding.
  always_comb begin
    w_alu_res = 32'd0;
    case (w_funct3)
      3'b000: w_alu_res = (w_is_op && inst_i[30]) ? (op1_i - op2_i) : (op1_i + op2_i);
      3'b001: w_alu_res = op1_i << w_shamt;
      3'b010: w_alu_res = {31'd0, $signed(op1_i) < $signed(op2_i)};
      3'b011: w_alu_res = {31'd0, op1_i < op2_i};
      3'b100: w_alu_res = op1_i ^ op2_i;
      3'b101: w_alu_res = inst_i[30] ? 32'($signed(op1_i) >>> w_shamt) : (op1_i >> w_shamt);
      3'b110: w_alu_res = op1_i | op2_i;
      3'b111: w_alu_res = op1_i & op2_i;
      default: w_alu_res = 32'd0;
    endcase
  end

  // MUL family: one signed 66-bit product, operands sign- or zero-extended per funct3.
  assign w_mul_a_sgn = ((w_funct3 == 3'b001) || (w_funct3 == 3'b010)) && op1_i[31];
  assign w_mul_b_sgn = (w_funct3 == 3'b001) && op2_i[31];
  assign w_mul_a     = {{34{w_mul_a_sgn}}, op1_i};
  assign w_mul_b     = {{34{w_mul_b_sgn}}, op2_i};
  assign w_mul_prod  = w_mul_a * w_mul_b;
  assign w_mul_res   = (w_funct3 == 3'b000) ? w_mul_prod[31:0] : w_mul_prod[63:32];

  // Divider operand magnitudes; DIV/REM (funct3[0]=0) are the signed forms.
  assign w_div_sgn = ~w_funct3[0];
  assign w_a_neg   = w_div_sgn && op1_i[31];
  assign w_b_neg   = w_div_sgn && op2_i[31];
  assign w_dvd_mag = w_a_neg ? (32'd0 - op1_i) : op1_i;
  assign w_dvs_mag = w_b_neg ? (32'd0 - op2_i) : op2_i;

  // One restoring step: shift {rem,quot} left, keep the difference if it is non-negative.
  assign w_rem_sh = {r_rem, r_quot[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};
  assign w_ge     = ~w_diff[32];

  // Sign correction applied to whatever the divider currently holds.
  always_comb begin
    w_div_res = 32'd0;
    if (r_is_rem) w_div_res = r_neg_r ? (32'd0 - r_rem) : r_rem;
    else          w_div_res = r_neg_q ? (32'd0 - r_quot) : r_quot;
  end

  // Divider FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Divider FSM next state and stall request; DONE always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            w_stall     = 1'b1;
            w_state_nxt = (op2_i == 32'd0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          w_stall = 1'b1;
          if (r_cnt == 5'(DIV_ITER - 1)) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Divider datapath: latch operands on start, then iterate in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_quot    <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (!flush_i) begin
      if ((r_state == S_IDLE) && w_is_div) begin
        r_cnt     <= 5'd0;
        r_divisor <= w_dvs_mag;
        r_is_rem  <= w_funct3[1];
        r_neg_r   <= w_a_neg;
        r_neg_q   <= (w_a_neg ^ w_b_neg) && (op2_i != 32'd0);
        if (op2_i == 32'd0) begin
          // Divide by zero: all-ones quotient, dividend as remainder.
          r_quot <= 32'hFFFF_FFFF;
          r_rem  <= w_dvd_mag;
        end else begin
          r_quot <= w_dvd_mag;
          r_rem  <= 32'd0;
        end
      end else if (r_state == S_CALC) begin
        r_cnt  <= r_cnt + 5'd1;
        r_quot <= {r_quot[30:0], w_ge};
        r_rem  <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
      end
    end
  end

  // Output mux: divider owns rd_data while busy, otherwise the combinational result.
  always_comb begin
    rd_data_o = 32'd0;
    if (r_state != S_IDLE)            rd_data_o = w_div_res;
    else if (w_is_opimm || w_is_op)   rd_data_o = w_alu_res;
    else if (w_is_m && !w_funct3[2])  rd_data_o = w_mul_res;
  end

  assign stall_o     = w_stall && !rst;
  assign regs_wen_o  = regs_wen_i && (rd_addr_i != 5'd0) && !flush_i && !stall_o;
  assign instaddr_o  = instaddr_i;
  assign rd_addr_o   = rd_addr_i;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_alu_div.sv
// Bench for ex_alu_div: arithmetic reference model, expected-result queues,
// directed corner cases, randomized instruction stream.
module tb_ex_alu_div;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OPC   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        wen = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        flush = 1'b0;
  logic [31:0] instaddr_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        regs_wen_o;
  logic        stall_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  logic tb_valid = 1'b0;

  logic [31:0] exp_q[$];
  logic        exp_wen_q[$];
  int          exp_stall_q[$];

  ex_alu_div #(.DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .inst_i(inst), .instaddr_i(pc), .op1_i(op1), .op2_i(op2),
    .regs_wen_i(wen), .rd_addr_i(rd), .flush_i(flush), .instaddr_o(instaddr_o),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .regs_wen_o(regs_wen_o),
    .stall_o(stall_o), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Reference model: result of one instruction from plain 64-bit arithmetic.
  function automatic logic [31:0] model_res(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    longint      sa, sb, ua, ub, p;
    logic [63:0] up;
    logic [31:0] r;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; sh = b[4:0];
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    r = 32'd0;
    if (opc == OPIMM || (opc == OPC && (f7 == 7'h00 || f7 == 7'h20))) begin
      case (f3)
        3'd0: r = (opc == OPC && f7 == 7'h20) ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: begin p = sa >>> sh; r = i[30] ? p[31:0] : (a >> sh); end
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (opc == OPC && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * ub; r = p[63:32]; end
        3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
        3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int model_stall(input logic [31:0] i, input logic [31:0] b);
    if (i[6:0] == OPC && i[31:25] == 7'h01 && i[14]) return (b == 0) ? 1 : 33;
    return 0;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Driver: present one instruction, hold it while stall_o, release after its result cycle.
  task automatic run_inst(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic w);
    bit done;
    inst = i; op1 = a; op2 = b; rd = r; wen = w; pc = $urandom & 32'hFFFF_FFFC;
    exp_q.push_back(model_res(i, a, b));
    exp_wen_q.push_back(w && (r != 5'd0));
    exp_stall_q.push_back(model_stall(i, b));
    tb_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
    end
    if (!done) begin
      chk("result_timeout", 32'd0, 32'd1);
      exp_q.delete(); exp_wen_q.delete(); exp_stall_q.delete();
      stall_cnt = 0;
    end
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
  endtask

  // Scoreboard: check outputs every cycle an instruction is under test.
  always @(negedge clk) begin
    if (tb_valid && !rst && !flush) begin
      if (stall_o) begin
        stall_cnt++;
        chk("wen_during_stall", {31'd0, regs_wen_o}, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd0, 32'd1);
      end else begin
        logic [31:0] e_d;
        logic        e_w;
        int          e_s;
        e_d = exp_q.pop_front();
        e_w = exp_wen_q.pop_front();
        e_s = exp_stall_q.pop_front();
        chk("rd_data", rd_data_o, e_d);
        chk("regs_wen", {31'd0, regs_wen_o}, {31'd0, e_w});
        chk("stall_cycles", 32'(stall_cnt), 32'(e_s));
        chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, rd});
        chk("instaddr", instaddr_o, pc);
        stall_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] ADD, SRAI, DIV, DIVU, REM, REMU, MULH;
    ADD  = enc(OPC, 3'd0, 7'h00);
    SRAI = enc(OPIMM, 3'd5, 7'h20);
    MULH = enc(OPC, 3'd1, 7'h01);
    DIV  = enc(OPC, 3'd4, 7'h01);
    DIVU = enc(OPC, 3'd5, 7'h01);
    REM  = enc(OPC, 3'd6, 7'h01);
    REMU = enc(OPC, 3'd7, 7'h01);

    // Model pins: hand-computed values.
    chk("pin_add",   model_res(ADD, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    chk("pin_srai",  model_res(SRAI, 32'h8000_0000, 32'd4), 32'hF800_0000);
    chk("pin_div",   model_res(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem",   model_res(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_divu0", model_res(DIVU, 32'h1234, 32'd0), 32'hFFFF_FFFF);
    chk("pin_remu0", model_res(REMU, 32'h1234, 32'd0), 32'h1234);
    chk("pin_divov", model_res(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("pin_remov", model_res(REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    chk("pin_mulh",  model_res(MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    chk("pin_divu",  model_res(DIVU, 32'd100, 32'd7), 32'd14);

    // Reset state
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state_o}, 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_wen", {31'd0, regs_wen_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed
    run_inst(ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
    run_inst(SRAI, 32'h8000_0000, 32'd4, 5'd6, 1'b1);
    run_inst(DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    run_inst(REM, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    run_inst(DIVU, 32'h1234, 32'd0, 5'd7, 1'b1);
    run_inst(REMU, 32'h1234, 32'd0, 5'd7, 1'b1);
    run_inst(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    run_inst(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    run_inst(DIV, 32'h8000_0000, 32'd0, 5'd8, 1'b1);
    run_inst(REM, 32'hFFFF_FFF9, 32'd0, 5'd8, 1'b1);
    run_inst(MULH, 32'h8000_0000, 32'h8000_0000, 5'd9, 1'b1);
    run_inst(ADD, 32'd3, 32'd4, 5'd0, 1'b1);
    run_inst(enc(7'b0000011, 3'd2, 7'h00), 32'd3, 32'd4, 5'd2, 1'b1);

    // Flush in the 10th CALC cycle
    inst = DIVU; op1 = 32'd100; op2 = 32'd7; rd = 5'd4; wen = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_flush_stall", {31'd0, stall_o}, 32'd1);
    chk("pre_flush_state", {30'd0, dbg_state_o}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_wen", {31'd0, regs_wen_o}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("post_flush_state", {30'd0, dbg_state_o}, 32'd0);
    run_inst(DIVU, 32'd100, 32'd7, 5'd4, 1'b1);

    // Asynchronous reset mid-CALC
    inst = DIV; op1 = 32'hFFFF_FFF9; op2 = 32'd2; rd = 5'd3; wen = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stall_o}, 32'd0);
    chk("arst_state", {30'd0, dbg_state_o}, 32'd0);
    inst = ADD;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    run_inst(ADD, 32'd5, 32'd6, 5'd1, 1'b1);
    run_inst(DIVU, 32'd100, 32'd7, 5'd4, 1'b1);

    // Random stream
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ri;
      int c;
      c = $urandom_range(0, 11);
      if (c <= 2)      ri = enc(OPIMM, 3'($urandom_range(0, 7)), $urandom_range(0, 1) ? 7'h20 : 7'h00);
      else if (c <= 5) ri = enc(OPC, 3'($urandom_range(0, 7)), $urandom_range(0, 1) ? 7'h20 : 7'h00);
      else if (c <= 7) ri = enc(OPC, 3'($urandom_range(0, 3)), 7'h01);
      else if (c <= 10) ri = enc(OPC, 3'($urandom_range(4, 7)), 7'h01);
      else             ri = enc($urandom_range(0, 1) ? 7'b0000011 : 7'b1101111, 3'($urandom_range(0, 7)), 7'h00);
      run_inst(ri, rand_op(), rand_op(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
